// File: rtl/gpu_alu_pkg.sv
// Shared definitions for the GPU ALU and the round-robin scheduler that fronts it:
// opcode encoding, opcode width and the scheduler state encoding.
package gpu_alu_pkg;

    localparam int CTRL_WIDTH = 2;

    localparam logic [CTRL_WIDTH-1:0] ALU_CTRL_ADD = 2'd0;
    localparam logic [CTRL_WIDTH-1:0] ALU_CTRL_SUB = 2'd1;
    localparam logic [CTRL_WIDTH-1:0] ALU_CTRL_SL  = 2'd2;
    localparam logic [CTRL_WIDTH-1:0] ALU_CTRL_SR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/alu_rr_scheduler_rr_picker.sv
// Combinational round-robin priority picker: searches upward from rr_ptr
// (wrapping) and grants the first asserted request.
module rr_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any_valid
);

    // First valid request at or after rr_ptr wins; later candidates are masked by any_valid
    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                any_valid = 1'b1;
                winner    = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
                grant[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one external ALU between NUM_REQ requesters.
// One op in flight: IDLE (arbitrate/accept) -> EXEC (ALU evaluates latched
// operands) -> RESP (hold tagged result until the consumer takes it).
module alu_rr_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int CTRL_WIDTH = gpu_alu_pkg::CTRL_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opA,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opB,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl,
    output logic [DATA_WIDTH-1:0]         alu_inA,
    output logic [DATA_WIDTH-1:0]         alu_inB,
    output logic [CTRL_WIDTH-1:0]         alu_ctrl,
    input  logic [DATA_WIDTH-1:0]         alu_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id
);

    import gpu_alu_pkg::*;

    sched_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   winner;
    logic                  any_valid;
    logic                  accept;

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // State and datapath registers; reset clears everything so an in-flight op is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
        end
    end

    // Next-state: EXEC is always exactly one cycle; RESP waits for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register updates: latch the winner's op on accept, capture the ALU result in EXEC
    always_comb begin
        accept   = (state_q == IDLE) && any_valid;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        if (accept) begin
            id_d     = winner;
            opa_d    = req_opA[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            opb_d    = req_opB[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            ctrl_d   = req_ctrl[int'(winner)*CTRL_WIDTH +: CTRL_WIDTH];
            rr_ptr_d = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
        if (state_q == EXEC) begin
            result_d = alu_out;
        end
    end

    // Outputs: ALU inputs always come from the latched regs so they never toggle while idle;
    // req_ready is gated by rst_n because the async-reset state alone would still expose grants
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && any_valid) begin
            req_ready = grant;
        end
        alu_inA   = opa_q;
        alu_inB   = opb_q;
        alu_ctrl  = ctrl_q;
        rsp_valid = (state_q == RESP);
        rsp_data  = result_q;
        rsp_id    = id_q;
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler with a behavioural ALU attached.
module tb_alu_rr_scheduler;

    localparam int DW = 16;
    localparam int CW = 2;
    localparam int NR = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_opA = '0;
    logic [NR*DW-1:0] req_opB = '0;
    logic [NR*CW-1:0] req_ctrl = '0;
    logic [DW-1:0]    alu_inA, alu_inB, alu_out;
    logic [CW-1:0]    alu_ctrl;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;

    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    alu_rr_scheduler #(
        .DATA_WIDTH (DW),
        .CTRL_WIDTH (CW),
        .NUM_REQ    (NR),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opA   (req_opA),
        .req_opB   (req_opB),
        .req_ctrl  (req_ctrl),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    // External ALU model
    always_comb begin
        case (alu_ctrl)
            2'd0:    alu_out = alu_inA + alu_inB;
            2'd1:    alu_out = alu_inA - alu_inB;
            2'd2:    alu_out = alu_inA << alu_inB;
            default: alu_out = alu_inA >> alu_inB;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every completed response handshake is matched against the queue head
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic set_slot(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [CW-1:0] c);
        req_opA[id*DW +: DW] = a;
        req_opB[id*DW +: DW] = b;
        req_ctrl[id*CW +: CW] = c;
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = IW'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for any grant, checks it, and returns just after the accepting edge
    task automatic wait_grant(input logic [NR-1:0] exp, input string nm);
        bit got = 0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (req_ready != '0) got = 1;
        end
        chk(nm, 32'(req_ready), 32'(exp));
        if (got) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_alu_inA", 32'(alu_inA), 32'd0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Single-requester op with pass-through check on the ALU inputs during EXEC
    task automatic issue_one(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [CW-1:0] c, input logic [DW-1:0] e);
        set_slot(id, a, b, c);
        push(id, e);
        req_valid = NR'(1) << id;
        wait_grant(NR'(1) << id, "grant_single");
        req_valid = '0;
        @(negedge clk);
        chk("alu_inA", 32'(alu_inA), 32'(a));
        chk("alu_inB", 32'(alu_inB), 32'(b));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(c));
        drain();
    endtask

    initial begin
        #2;
        do_reset();

        // 1: single op, latency
        set_slot(0, 16'd5, 16'd3, 2'd1);
        push(0, 16'd2);
        req_valid = 4'b0001;
        wait_grant(4'b0001, "t1_grant");
        req_valid = '0;
        @(negedge clk);
        chk("t1_exec_no_rsp", 32'(rsp_valid), 32'd0);
        chk("t1_exec_no_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        drain();

        // 2: all requesters valid from rr_ptr=0
        do_reset();
        set_slot(0, 16'h0100, 16'd1, 2'd0);
        set_slot(1, 16'h0200, 16'd2, 2'd1);
        set_slot(2, 16'h0300, 16'd3, 2'd2);
        set_slot(3, 16'h0400, 16'd4, 2'd3);
        push(0, 16'h0101);
        push(1, 16'h01FE);
        push(2, 16'h1800);
        push(3, 16'h0040);
        push(0, 16'h0101);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(NR'(1) << (k % NR), "t2_grant_order");
            if (k == 4) req_valid = '0;
        end
        drain();

        // 3: backpressure while another requester waits
        rsp_ready = 1'b0;
        set_slot(2, 16'h1111, 16'h2222, 2'd0);
        push(2, 16'h3333);
        push(3, 16'hFFFE);
        req_valid = 4'b0100;
        wait_grant(4'b0100, "t3_grant");
        set_slot(3, 16'h0005, 16'h0007, 2'd1);
        req_valid = 4'b1000;
        begin
            bit seen = 0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            chk("t3_rsp_seen", 32'(seen), 32'd1);
        end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) @(negedge clk);
            chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t3_hold_data", 32'(rsp_data), 32'h3333);
            chk("t3_hold_id", 32'(rsp_id), 32'd2);
            chk("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(4'b1000, "t3_next_grant");
        req_valid = '0;
        drain();

        // 4: arithmetic edges through requester 1
        issue_one(1, 16'h0000, 16'h0001, 2'd1, 16'hFFFF);
        issue_one(1, 16'hFFFF, 16'h0001, 2'd0, 16'h0000);
        issue_one(1, 16'h0001, 16'd15, 2'd2, 16'h8000);
        issue_one(1, 16'h8000, 16'd16, 2'd3, 16'h0000);

        // 5: wrap from requester 3 back to 0
        issue_one(3, 16'h000A, 16'd3, 2'd2, 16'h0050);
        set_slot(0, 16'd1, 16'd1, 2'd0);
        set_slot(3, 16'h0F00, 16'd8, 2'd3);
        push(0, 16'h0002);
        push(3, 16'h000F);
        req_valid = 4'b1001;
        wait_grant(4'b0001, "t5_grant0");
        req_valid = 4'b1000;
        wait_grant(4'b1000, "t5_grant3");
        req_valid = '0;
        drain();

        // 6: async reset in EXEC
        set_slot(2, 16'h1234, 16'h0001, 2'd0);
        req_valid = 4'b0100;
        wait_grant(4'b0100, "t6_grant");
        rst_n = 1'b0;
        #1;
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        chk("t6_alu_inA", 32'(alu_inA), 32'd0);
        chk("t6_alu_inB", 32'(alu_inB), 32'd0);
        chk("t6_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_rsp_data", 32'(rsp_data), 32'd0);
        chk("t6_rsp_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        set_slot(0, 16'h0010, 16'h0001, 2'd1);
        push(0, 16'h000F);
        req_valid = 4'b1111;
        wait_grant(4'b0001, "t6_grant_after_rst");
        req_valid = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
